// File: rtl/delay_line_feeder.sv
// delay_line_feeder
//   Paced upstream source for an 8-bit tapped delay line. Bytes arrive over a
//   valid/ready handshake into a small FIFO. In RUN, one byte is released every
//   TICK_DIV clocks onto d_out. A 2-bit tap select is held on sel_out.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_data      in   byte to enqueue
//   in_valid     in   in_data is valid
//   in_ready     out  FIFO can accept (fifo_count < DEPTH)
//   sel_in       in   new tap select
//   sel_load     in   load sel_in into sel_out
//   d_out        out  most recently released byte (delay line d)
//   d_valid      out  one-clock pulse when d_out updates
//   sel_out      out  tap select (delay line sel)
//   fifo_count   out  entries held, 0..DEPTH
//   underrun_cnt out  saturating underrun counter (only with FEEDER_UNDERRUN_CNT_EN)
//
// Configuration
//   FEEDER_UNDERRUN_CNT_EN : when defined, adds the underrun_cnt port and counter.

module delay_line_feeder #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               sel_in,
  input  logic                     sel_load,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_valid,
  output logic [1:0]               sel_out,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]               underrun_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TICK_DIV);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic [TW-1:0]    tick_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push;
  logic tick;
  logic pop;

  // Ready is decoded from the registered count only, so a pop never frees a
  // slot for a push in the same cycle.
  assign in_ready = (32'(fifo_count) < DEPTH);
  assign push     = in_valid & in_ready;
  assign tick     = (state_q == StRun) && (tick_q == TW'(TICK_DIV - 1));
  // Uses the registered count: a byte pushed this cycle cannot be popped yet.
  assign pop      = tick && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tick_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_count <= '0;
      d_out      <= '0;
      d_valid    <= 1'b0;
      sel_out    <= 2'b00;
`ifdef FEEDER_UNDERRUN_CNT_EN
      underrun_cnt <= 8'h00;
`endif
    end else begin
      d_valid <= 1'b0;

      if (sel_load) begin
        sel_out <= sel_in;
      end

      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end

      if (pop) begin
        d_out    <= mem_q[rd_ptr_q];
        d_valid  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      case (state_q)
        StIdle: begin
          tick_q <= '0;
          if (fifo_count != '0) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (tick) begin
            tick_q <= '0;
            if (fifo_count == '0) begin
              // Underrun: d_out keeps its last value, wait for new data.
              state_q <= StIdle;
`ifdef FEEDER_UNDERRUN_CNT_EN
              if (underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
              end
`endif
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tick_q  <= '0;
        end
      endcase
    end
  end

endmodule
